ascon_ctrl: RTL and testbench
=============================

Name: ascon_ctrl

Overview:
Sequencing FSM for the Ascon-128 AEAD datapath: state register plus a one-round-per-cycle permutation that uses the shared round-constant and S-box tables. Drives permutation enable and round index, and issues load/XOR strobes through the four AEAD phases: init, associated data, message, finalization. Handles valid/ready handshakes for AD input, message input, ciphertext output and tag output. Holds no data; all 320-bit state and padding live in the datapath.

Parameters:
PA_ROUNDS, 12, rounds of p^a (init/final); legal 1..12; round index starts at 12-PA_ROUNDS
PB_ROUNDS, 6, rounds of p^b (AD/message); legal 1..12; round index starts at 12-PB_ROUNDS

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  start one AEAD operation; sampled only in IDLE
decrypt_i  in  1  mode at start (0 encrypt, 1 decrypt); latched
no_ad_i  in  1  AD empty at start; latched
ad_valid_i / ad_last_i  in  1/1  AD block valid / final padded AD block
ad_ready_o  out  1  controller accepts AD block
msg_valid_i / msg_last_i  in  1/1  message block valid / final padded block
msg_ready_o  out  1  controller accepts message block
out_valid_o  out  1  ciphertext/plaintext block (x0) valid
out_ready_i  in  1  consumer accepts output block
tag_valid_o  out  1  tag (x3,x4 xor K) valid
tag_ready_i  in  1  consumer accepts tag
load_o  out  1  load IV||K||N into state
round_en_o  out  1  apply one permutation round this cycle
rnd_o  out  4  round-constant index
xor_data_o  out  1  absorb input block into x0 (datapath uses mode_o)
xor_key_tail_o  out  1  x3,x4 ^= K (end of init)
xor_key_mid_o  out  1  x1,x2 ^= K (start of final)
dom_sep_o  out  1  x4 ^= 1
mode_o  out  1  latched decrypt_i
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse on tag handshake

Behaviour:
- Reset: state IDLE, round counter 0, mode/no_ad/last latches 0; all outputs 0.
- Outputs are Moore (decoded from state) except xor_data_o, asserted in the cycle of ad or msg handshake.
- States and transitions:
  IDLE: start_i -> LOAD; latch decrypt_i, no_ad_i.
  LOAD: load_o=1 -> INIT_PERM.
  INIT_PERM: round_en_o=1 for PA_ROUNDS cycles; rnd_o = 12-PA_ROUNDS+k, k=0.. -> INIT_KEY.
  INIT_KEY: xor_key_tail_o=1 -> DOMSEP if no_ad latched, else AD_WAIT.
  AD_WAIT: ad_ready_o=1; on ad_valid_i: xor_data_o=1, latch ad_last_i -> AD_PERM.
  AD_PERM: PB_ROUNDS rounds from index 12-PB_ROUNDS -> DOMSEP if last, else AD_WAIT.
  DOMSEP: dom_sep_o=1 -> MSG_WAIT.
  MSG_WAIT: msg_ready_o=1; on msg_valid_i: xor_data_o=1, latch msg_last_i -> MSG_OUT.
  MSG_OUT: out_valid_o=1 until out_ready_i; then FINAL_KEY if last, else MSG_PERM.
  MSG_PERM: PB_ROUNDS rounds -> MSG_WAIT.
  FINAL_KEY: xor_key_mid_o=1 -> FINAL_PERM.
  FINAL_PERM: PA_ROUNDS rounds -> TAG.
  TAG: tag_valid_o=1 until tag_ready_i; on handshake done_o=1, -> IDLE.
- Round counter counts down from N-1; leaves PERM states when it reaches 0. rnd_o=0 outside PERM states.
- Message phase always sees >=1 block; last block gets no trailing p^b.
- start_i outside IDLE ignored; valid inputs outside their WAIT state ignored (ready low).
- out_valid_o/tag_valid_o stay high and stable until accepted.
- Latency, no AD, single message block, valid/ready always high: start accepted cycle 0; load_o cycle 1; tag_valid_o cycle 31 for default parameters.
- rst_i mid-operation: IDLE on next edge; all strobes low that cycle.

Optional Feature:
ASCON_CTRL_ABORT_EN: adds input abort_i (1 bit). When defined, abort_i high in any non-IDLE state forces IDLE next cycle with no done_o pulse; it has priority over handshakes, and any xor_data_o in that cycle is suppressed. When undefined, the port is absent and an operation runs only to completion or reset.

Test Plan:
- no_ad_i=1, single msg block, all ready high, defaults -> load_o at cycle 1, round_en_o cycles 2-13 with rnd_o 0..11, dom_sep_o cycle 15, tag_valid_o cycle 31, done_o on handshake.
- 2 AD blocks, 3 msg blocks -> two 6-round bursts with rnd_o 6..11 after AD; 2 MSG_PERM bursts; no p^b after the last msg block; 3 out handshakes.
- out_ready_i low 5 cycles in MSG_OUT, tag_ready_i low 3 cycles -> out_valid_o/tag_valid_o held, no round_en_o, state frozen.
- start_i and ad_valid_i pulsed during FINAL_PERM -> ignored; ad_ready_o stays 0; sequence unchanged.
- PA_ROUNDS=8, PB_ROUNDS=4 -> init rnd_o 4..11, AD rnd_o 8..11.
- rst_i asserted mid AD_PERM -> next cycle busy_o=0, all strobes 0; new start runs cleanly. With ASCON_CTRL_ABORT_EN, abort_i in MSG_WAIT -> IDLE, no done_o.

Source files
------------

// File: rtl/ascon_ctrl.sv
// ascon_ctrl: sequencing FSM for the Ascon-128 AEAD datapath (init, AD, message, final).
// Latency: start -> load_o next cycle; one permutation round per cycle; 31 cycles start->tag
//          for default rounds, no AD, one message block, all handshakes ready.
// Backpressure: ad/msg accepted only in their WAIT states; out/tag valid held stable until ready.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i, decrypt_i, no_ad_i   operation start (IDLE only); mode and empty-AD latched at start
//   ad_valid_i/ad_last_i/ad_ready_o      AD block handshake
//   msg_valid_i/msg_last_i/msg_ready_o   message block handshake
//   out_valid_o/out_ready_i  ciphertext/plaintext block (x0) handshake
//   tag_valid_o/tag_ready_i  tag handshake; done_o pulses in the tag handshake cycle
//   load_o, round_en_o, rnd_o, xor_data_o, xor_key_tail_o, xor_key_mid_o, dom_sep_o  datapath strobes
//   mode_o, busy_o           latched decrypt flag, controller not idle
//   abort_i                  only with ASCON_CTRL_ABORT_EN: return to IDLE without done_o
//
// Optional feature macro: ASCON_CTRL_ABORT_EN

module ascon_ctrl #(
    parameter int PA_ROUNDS = 12,
    parameter int PB_ROUNDS = 6
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       decrypt_i,
    input  logic       no_ad_i,
    input  logic       ad_valid_i,
    input  logic       ad_last_i,
    output logic       ad_ready_o,
    input  logic       msg_valid_i,
    input  logic       msg_last_i,
    output logic       msg_ready_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       tag_valid_o,
    input  logic       tag_ready_i,
`ifdef ASCON_CTRL_ABORT_EN
    input  logic       abort_i,
`endif
    output logic       load_o,
    output logic       round_en_o,
    output logic [3:0] rnd_o,
    output logic       xor_data_o,
    output logic       xor_key_tail_o,
    output logic       xor_key_mid_o,
    output logic       dom_sep_o,
    output logic       mode_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_INIT_PERM, S_INIT_KEY, S_AD_WAIT, S_AD_PERM, S_DOMSEP,
        S_MSG_WAIT, S_MSG_OUT, S_MSG_PERM, S_FINAL_KEY, S_FINAL_PERM, S_TAG
    } state_e;

    localparam logic [3:0] PA_LAST = 4'(PA_ROUNDS - 1);
    localparam logic [3:0] PB_LAST = 4'(PB_ROUNDS - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mode_q, mode_d;
    logic       no_ad_q, no_ad_d;
    logic       last_q, last_d;
    logic       abort_w;
    logic       ad_hs, msg_hs, out_hs, tag_hs;
    logic       perm_d;

`ifdef ASCON_CTRL_ABORT_EN
    assign abort_w = abort_i & (state_q != S_IDLE);
`else
    assign abort_w = 1'b0;
`endif

    assign ad_hs  = ad_ready_o & ad_valid_i;
    assign msg_hs = msg_ready_o & msg_valid_i;
    assign out_hs = out_valid_o & out_ready_i;
    assign tag_hs = tag_valid_o & tag_ready_i;

    // The only non-Moore strobes: absorb and completion happen in the handshake cycle itself.
    assign xor_data_o = (ad_hs | msg_hs) & ~abort_w;
    assign done_o     = tag_hs & ~abort_w;
    assign mode_o     = mode_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        mode_d  = mode_q;
        no_ad_d = no_ad_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: if (start_i) begin
                state_d = S_LOAD;
                mode_d  = decrypt_i;
                no_ad_d = no_ad_i;
                last_d  = 1'b0;
            end
            S_LOAD: begin
                state_d = S_INIT_PERM;
                cnt_d   = PA_LAST;
            end
            S_INIT_PERM: begin
                if (cnt_q == 4'd0) state_d = S_INIT_KEY;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_INIT_KEY: state_d = no_ad_q ? S_DOMSEP : S_AD_WAIT;
            S_AD_WAIT: if (ad_hs) begin
                last_d  = ad_last_i;
                state_d = S_AD_PERM;
                cnt_d   = PB_LAST;
            end
            S_AD_PERM: begin
                if (cnt_q == 4'd0) state_d = last_q ? S_DOMSEP : S_AD_WAIT;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_DOMSEP: state_d = S_MSG_WAIT;
            S_MSG_WAIT: if (msg_hs) begin
                last_d  = msg_last_i;
                state_d = S_MSG_OUT;
            end
            // The final message block goes straight to finalization: no trailing p^b.
            S_MSG_OUT: if (out_hs) begin
                if (last_q) begin
                    state_d = S_FINAL_KEY;
                end else begin
                    state_d = S_MSG_PERM;
                    cnt_d   = PB_LAST;
                end
            end
            S_MSG_PERM: begin
                if (cnt_q == 4'd0) state_d = S_MSG_WAIT;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_FINAL_KEY: begin
                state_d = S_FINAL_PERM;
                cnt_d   = PA_LAST;
            end
            S_FINAL_PERM: begin
                if (cnt_q == 4'd0) state_d = S_TAG;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_TAG: if (tag_hs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_w) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    assign perm_d = (state_d == S_INIT_PERM) || (state_d == S_AD_PERM) ||
                    (state_d == S_MSG_PERM)  || (state_d == S_FINAL_PERM);

    // Outputs are registered by decoding the next state; the counter runs N-1..0,
    // so the round index 12-N+k is simply 11-cnt.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            mode_q         <= 1'b0;
            no_ad_q        <= 1'b0;
            last_q         <= 1'b0;
            load_o         <= 1'b0;
            round_en_o     <= 1'b0;
            rnd_o          <= '0;
            xor_key_tail_o <= 1'b0;
            xor_key_mid_o  <= 1'b0;
            dom_sep_o      <= 1'b0;
            ad_ready_o     <= 1'b0;
            msg_ready_o    <= 1'b0;
            out_valid_o    <= 1'b0;
            tag_valid_o    <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mode_q         <= mode_d;
            no_ad_q        <= no_ad_d;
            last_q         <= last_d;
            load_o         <= (state_d == S_LOAD);
            round_en_o     <= perm_d;
            rnd_o          <= perm_d ? (4'd11 - cnt_d) : 4'd0;
            xor_key_tail_o <= (state_d == S_INIT_KEY);
            xor_key_mid_o  <= (state_d == S_FINAL_KEY);
            dom_sep_o      <= (state_d == S_DOMSEP);
            ad_ready_o     <= (state_d == S_AD_WAIT);
            msg_ready_o    <= (state_d == S_MSG_WAIT);
            out_valid_o    <= (state_d == S_MSG_OUT);
            tag_valid_o    <= (state_d == S_TAG);
            busy_o         <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_ascon_ctrl.sv
module tb_ascon_ctrl;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic rst_i, start_i, decrypt_i, no_ad_i, ad_valid_i, ad_last_i, msg_valid_i, msg_last_i;
    logic out_ready_i, tag_ready_i, abort_i;

    logic ad_ready_o, msg_ready_o, out_valid_o, tag_valid_o, load_o, round_en_o;
    logic [3:0] rnd_o;
    logic xor_data_o, xor_key_tail_o, xor_key_mid_o, dom_sep_o, mode_o, busy_o, done_o;

    logic b_ad_ready, b_msg_ready, b_out_valid, b_tag_valid, b_load, b_round_en;
    logic [3:0] b_rnd;
    logic b_xor_data, b_xor_key_tail, b_xor_key_mid, b_dom_sep, b_mode, b_busy, b_done;

    ascon_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .decrypt_i(decrypt_i), .no_ad_i(no_ad_i),
        .ad_valid_i(ad_valid_i), .ad_last_i(ad_last_i), .ad_ready_o(ad_ready_o),
        .msg_valid_i(msg_valid_i), .msg_last_i(msg_last_i), .msg_ready_o(msg_ready_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .tag_valid_o(tag_valid_o), .tag_ready_i(tag_ready_i),
`ifdef ASCON_CTRL_ABORT_EN
        .abort_i(abort_i),
`endif
        .load_o(load_o), .round_en_o(round_en_o), .rnd_o(rnd_o), .xor_data_o(xor_data_o),
        .xor_key_tail_o(xor_key_tail_o), .xor_key_mid_o(xor_key_mid_o), .dom_sep_o(dom_sep_o),
        .mode_o(mode_o), .busy_o(busy_o), .done_o(done_o)
    );

    ascon_ctrl #(.PA_ROUNDS(8), .PB_ROUNDS(4)) dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .decrypt_i(decrypt_i), .no_ad_i(no_ad_i),
        .ad_valid_i(ad_valid_i), .ad_last_i(ad_last_i), .ad_ready_o(b_ad_ready),
        .msg_valid_i(msg_valid_i), .msg_last_i(msg_last_i), .msg_ready_o(b_msg_ready),
        .out_valid_o(b_out_valid), .out_ready_i(out_ready_i),
        .tag_valid_o(b_tag_valid), .tag_ready_i(tag_ready_i),
`ifdef ASCON_CTRL_ABORT_EN
        .abort_i(abort_i),
`endif
        .load_o(b_load), .round_en_o(b_round_en), .rnd_o(b_rnd), .xor_data_o(b_xor_data),
        .xor_key_tail_o(b_xor_key_tail), .xor_key_mid_o(b_xor_key_mid), .dom_sep_o(b_dom_sep),
        .mode_o(b_mode), .busy_o(b_busy), .done_o(b_done)
    );

    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_IPERM = 2, PH_IKEY = 3, PH_ADW = 4, PH_ADP = 5,
                   PH_DS = 6, PH_MW = 7, PH_MO = 8, PH_MP = 9, PH_FK = 10, PH_FP = 11, PH_TAG = 12;

    int vectors = 0;
    int miscompares = 0;
    int q_ph[$], q_k[$], q_idx[$], q_len[$];
    int g_nad, g_nmsg;

    // Expected cycle-by-cycle timeline, one entry per clock cycle.
    task automatic push(input int ph, input int len, input int idx);
        for (int k = 0; k < len; k++) begin
            q_ph.push_back(ph); q_k.push_back(k); q_idx.push_back(idx); q_len.push_back(len);
        end
    endtask

    task automatic build(input int n_ad, input int n_msg, input int out_stall, input int tag_stall,
                         input int pa, input int pb);
        q_ph.delete(); q_k.delete(); q_idx.delete(); q_len.delete();
        g_nad = n_ad; g_nmsg = n_msg;
        push(PH_IDLE, 1, 0); push(PH_LOAD, 1, 0); push(PH_IPERM, pa, 0); push(PH_IKEY, 1, 0);
        for (int j = 0; j < n_ad; j++) begin
            push(PH_ADW, 1, j); push(PH_ADP, pb, j);
        end
        push(PH_DS, 1, 0);
        for (int i = 0; i < n_msg; i++) begin
            push(PH_MW, 1, i);
            push(PH_MO, 1 + ((i == 0) ? out_stall : 0), i);
            if (i < n_msg - 1) push(PH_MP, pb, i);
        end
        push(PH_FK, 1, 0); push(PH_FP, pa, 0); push(PH_TAG, 1 + tag_stall, 0); push(PH_IDLE, 1, 0);
    endtask

    // {load, round_en, rnd[3:0], xor_data, key_tail, key_mid, dom_sep, out_valid, tag_valid, done, busy, ad_ready, msg_ready}
    function automatic logic [15:0] expv(input int ph, input int k, input int pa, input int pb,
                                         input logic adv, input logic msgv, input logic tagr,
                                         input logic abt);
        logic [3:0] r;
        logic perm, xd;
        r = 4'd0;
        if (ph == PH_IPERM || ph == PH_FP) r = 4'(12 - pa + k);
        if (ph == PH_ADP || ph == PH_MP)   r = 4'(12 - pb + k);
        perm = (ph == PH_IPERM) || (ph == PH_FP) || (ph == PH_ADP) || (ph == PH_MP);
        xd = ((ph == PH_ADW && adv) || (ph == PH_MW && msgv)) && !abt;
        return {ph == PH_LOAD, perm, r, xd, ph == PH_IKEY, ph == PH_FK, ph == PH_DS, ph == PH_MO,
                ph == PH_TAG, (ph == PH_TAG) && tagr && !abt, ph != PH_IDLE, ph == PH_ADW, ph == PH_MW};
    endfunction

    function automatic logic [15:0] obs(input bit use2);
        if (use2)
            return {b_load, b_round_en, b_rnd, b_xor_data, b_xor_key_tail, b_xor_key_mid, b_dom_sep,
                    b_out_valid, b_tag_valid, b_done, b_busy, b_ad_ready, b_msg_ready};
        return {load_o, round_en_o, rnd_o, xor_data_o, xor_key_tail_o, xor_key_mid_o, dom_sep_o,
                out_valid_o, tag_valid_o, done_o, busy_o, ad_ready_o, msg_ready_o};
    endfunction

    task automatic idle_inputs();
        start_i = 0; decrypt_i = 0; no_ad_i = 0; ad_valid_i = 0; ad_last_i = 0;
        msg_valid_i = 0; msg_last_i = 0; out_ready_i = 0; tag_ready_i = 0; abort_i = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    // Walks the timeline; inputs are derived from the expected phase of each cycle.
    task automatic run(input string name, input int pa, input int pb, input bit use2, input bit poke,
                       input logic dec, input int rst_at, input int abort_at);
        logic [15:0] e, o;
        for (int c = 0; c < q_ph.size(); c++) begin
            start_i     = (c == 0) || (poke && q_ph[c] == PH_FP && (q_k[c] == 2 || q_k[c] == 3));
            decrypt_i   = (c == 0) ? dec : ~dec;
            no_ad_i     = (c == 0) ? (g_nad == 0) : (g_nad != 0);
            ad_valid_i  = 1'b1;
            ad_last_i   = (q_idx[c] == g_nad - 1);
            msg_valid_i = 1'b1;
            msg_last_i  = (q_idx[c] == g_nmsg - 1);
            out_ready_i = !(q_ph[c] == PH_MO && q_k[c] < q_len[c] - 1);
            tag_ready_i = !(q_ph[c] == PH_TAG && q_k[c] < q_len[c] - 1);
            abort_i     = (c == abort_at);
            #1;
            e = expv(q_ph[c], q_k[c], pa, pb, ad_valid_i, msg_valid_i, tag_ready_i, abort_i);
            o = obs(use2);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, c, o, e);
            end
            if (c == rst_at || c == abort_at) begin
                rst_i = (c == rst_at);
                @(posedge clk_i); #1;
                rst_i = 1'b0;
                idle_inputs();
                #1;
                vectors++;
                if (obs(use2) !== 16'h0000) begin
                    miscompares++;
                    $display("FAIL %s_after cycle %0d: got %h expected 0000", name, c + 1, obs(use2));
                end
                return;
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic check_mode(input string name, input logic exp_mode);
        vectors++;
        if (mode_o !== exp_mode) begin
            miscompares++;
            $display("FAIL %s mode: got %b expected %b", name, mode_o, exp_mode);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        start_i = 1'b1;
        rst_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_i); #1;
            vectors++;
            if (obs(0) !== 16'h0000 || mode_o !== 1'b0) begin
                miscompares++;
                $display("FAIL reset: got %h/%b expected 0000/0", obs(0), mode_o);
            end
        end
        rst_i = 1'b0;
        start_i = 1'b0;
    endtask

    task automatic test_basic();
        apply_reset();
        build(0, 1, 0, 0, 12, 6);
        run("basic", 12, 6, 0, 0, 1'b1, -1, -1);
        check_mode("basic", 1'b1);
    endtask

    task automatic test_ad_msg();
        apply_reset();
        build(2, 3, 0, 0, 12, 6);
        run("ad_msg", 12, 6, 0, 0, 1'b0, -1, -1);
        check_mode("ad_msg", 1'b0);
    endtask

    task automatic test_stall();
        apply_reset();
        build(1, 2, 5, 3, 12, 6);
        run("stall", 12, 6, 0, 0, 1'b1, -1, -1);
    endtask

    task automatic test_ignore();
        apply_reset();
        build(0, 1, 0, 0, 12, 6);
        run("ignore", 12, 6, 0, 1, 1'b0, -1, -1);
    endtask

    task automatic test_params();
        apply_reset();
        build(1, 1, 0, 0, 8, 4);
        run("params", 8, 4, 1, 0, 1'b0, -1, -1);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        build(2, 1, 0, 0, 12, 6);
        run("rst_mid", 12, 6, 0, 0, 1'b0, 18, -1);
        build(0, 1, 0, 0, 12, 6);
        run("after_rst", 12, 6, 0, 0, 1'b1, -1, -1);
    endtask

`ifdef ASCON_CTRL_ABORT_EN
    task automatic test_abort();
        int at;
        apply_reset();
        build(1, 2, 0, 0, 12, 6);
        at = -1;
        for (int c = 0; c < q_ph.size(); c++)
            if (at < 0 && q_ph[c] == PH_MW) at = c;
        run("abort", 12, 6, 0, 0, 1'b0, -1, at);
        build(0, 1, 0, 0, 12, 6);
        run("after_abort", 12, 6, 0, 0, 1'b0, -1, -1);
    endtask
`endif

    initial begin
        rst_i = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_ad_msg();
        test_stall();
        test_ignore();
        test_params();
        test_reset_mid();
`ifdef ASCON_CTRL_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
